// File: rtl/counter_pkg.sv
// Shared definitions for the prescaled up/down counter family.
package counter_pkg;

    // Bound behaviour selected by the SATURATE input
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // CLOCK cycles per count step for a roughly 2 Hz step at 27 MHz
    localparam int DEFAULT_PRESCALE = 13500000;

    // Bits needed to hold the values 0..value-1 (at least 1)
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides CLOCK down to a one-cycle tick every PRESCALE enabled cycles.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int PS_WIDTH = clog2(PRESCALE)
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic ENABLE,
    input  logic CLEAR,
    output logic TICK
);

    localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);
    localparam logic [PS_WIDTH-1:0] PS_ONE  = PS_WIDTH'(1);

    logic [PS_WIDTH-1:0] ps;

    // Tick fires on the last enabled cycle of each prescale period
    assign TICK = ENABLE && (ps == PS_LAST);

    // Prescale counter: restarts on reset/clear, holds while disabled
    always_ff @(posedge CLOCK) begin
        if (RESET || CLEAR) begin
            ps <= '0;
        end else if (ENABLE) begin
            ps <= TICK ? '0 : ps + PS_ONE;
        end
    end

endmodule

// File: rtl/prescaled_updown_counter.sv
// Prescaled up/down counter with wrap/saturate bounds, load and cascade outputs.
module prescaled_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = 2**WIDTH - 1,
    parameter int PRESCALE  = DEFAULT_PRESCALE,
    parameter int PS_WIDTH  = 24
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             DIRECTION,
    input  logic             SATURATE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VALUE,
    output logic [WIDTH-1:0] COUNT_OUT,
    output logic             TICK_OUT,
    output logic             TC_OUT,
    output logic             AT_MAX,
    output logic             AT_ZERO
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // Loaded values above the modulus are clamped to the top count
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
        return (value > MAX_VAL) ? MAX_VAL : value;
    endfunction

    // One count step; returns {terminal_count, next_count}
    function automatic logic [WIDTH:0] step_count(
        input logic [WIDTH-1:0] cur,
        input logic             dir_up,
        input logic             sat_mode
    );
        logic             tc;
        logic [WIDTH-1:0] nxt;
        tc  = 1'b0;
        nxt = cur;
        if (dir_up) begin
            if (cur >= MAX_VAL) begin
                tc  = 1'b1;
                nxt = (sat_mode == MODE_SAT) ? MAX_VAL : '0;
            end else begin
                nxt = cur + ONE;
            end
        end else begin
            if (cur == '0) begin
                tc  = 1'b1;
                nxt = (sat_mode == MODE_SAT) ? '0 : MAX_VAL;
            end else begin
                nxt = cur - ONE;
            end
        end
        return {tc, nxt};
    endfunction

    logic             ps_tick_p0;
    logic [WIDTH-1:0] count_p1;
    logic             tick_p1;
    logic             tc_p1;

    // Stage p0: prescaler produces the step strobe; LOAD restarts the period
    tick_prescaler #(
        .PRESCALE (PRESCALE),
        .PS_WIDTH (PS_WIDTH)
    ) u_prescaler (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .ENABLE (ENABLE),
        .CLEAR  (LOAD),
        .TICK   (ps_tick_p0)
    );

    // Stage p1: count register and step pulses, priority reset > load > tick
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            count_p1 <= '0;
            tick_p1  <= 1'b0;
            tc_p1    <= 1'b0;
        end else if (LOAD) begin
            count_p1 <= clamp_load(LOAD_VALUE);
            tick_p1  <= 1'b0;
            tc_p1    <= 1'b0;
        end else if (ps_tick_p0) begin
            {tc_p1, count_p1} <= step_count(count_p1, DIRECTION, SATURATE);
            tick_p1           <= 1'b1;
        end else begin
            tick_p1 <= 1'b0;
            tc_p1   <= 1'b0;
        end
    end

    assign COUNT_OUT = count_p1;
    assign TICK_OUT  = tick_p1;
    assign TC_OUT    = tc_p1;
    assign AT_MAX    = (count_p1 == MAX_VAL);
    assign AT_ZERO   = (count_p1 == '0);

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Bench for prescaled_updown_counter: vector table, directed corner sequences
// and randomized traffic against a behavioural model.
module tb_prescaled_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=4, MAX_VALUE=9, PRESCALE=4
    logic       a_rst, a_en, a_dir, a_sat, a_load;
    logic [3:0] a_lv;
    logic [3:0] a_count;
    logic       a_tick, a_tc, a_amax, a_azero;

    // Instance B: WIDTH=2, MAX_VALUE=3, PRESCALE=1
    logic       b_rst, b_en, b_dir, b_sat, b_load;
    logic [1:0] b_lv;
    logic [1:0] b_count;
    logic       b_tick, b_tc, b_amax, b_azero;

    prescaled_updown_counter #(
        .WIDTH(4), .MAX_VALUE(9), .PRESCALE(4), .PS_WIDTH(3)
    ) u_a (
        .CLOCK(clk), .RESET(a_rst), .ENABLE(a_en), .DIRECTION(a_dir),
        .SATURATE(a_sat), .LOAD(a_load), .LOAD_VALUE(a_lv),
        .COUNT_OUT(a_count), .TICK_OUT(a_tick), .TC_OUT(a_tc),
        .AT_MAX(a_amax), .AT_ZERO(a_azero)
    );

    prescaled_updown_counter #(
        .WIDTH(2), .MAX_VALUE(3), .PRESCALE(1), .PS_WIDTH(1)
    ) u_b (
        .CLOCK(clk), .RESET(b_rst), .ENABLE(b_en), .DIRECTION(b_dir),
        .SATURATE(b_sat), .LOAD(b_load), .LOAD_VALUE(b_lv),
        .COUNT_OUT(b_count), .TICK_OUT(b_tick), .TC_OUT(b_tc),
        .AT_MAX(b_amax), .AT_ZERO(b_azero)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: count kept as a plain integer, steps done with
    // modular arithmetic, prescale tracked as total enabled cycles since restart.
    typedef struct {
        int count;
        int en_cycles;
        bit tick;
        bit tc;
    } mstate_t;

    mstate_t ma = '{0, 0, 1'b0, 1'b0};
    mstate_t mb = '{0, 0, 1'b0, 1'b0};

    function automatic mstate_t model_next(input mstate_t s, input int maxv, input int presc,
                                           input bit rst, input bit en, input bit dir,
                                           input bit sat, input bit load, input int lv);
        mstate_t n;
        int target;
        n = s;
        n.tick = 1'b0;
        n.tc   = 1'b0;
        if (rst) begin
            n.count = 0;
            n.en_cycles = 0;
        end else if (load) begin
            n.count = (lv > maxv) ? maxv : lv;
            n.en_cycles = 0;
        end else if (en) begin
            n.en_cycles = s.en_cycles + 1;
            if (n.en_cycles % presc == 0) begin
                n.tick = 1'b1;
                target = dir ? s.count + 1 : s.count - 1;
                if (target > maxv || target < 0) begin
                    n.tc = 1'b1;
                    n.count = sat ? s.count : (target + maxv + 1) % (maxv + 1);
                end else begin
                    n.count = target;
                end
            end
        end
        return n;
    endfunction

    task automatic set_a(input bit rst, input bit en, input bit dir, input bit sat,
                         input bit load, input int lv);
        a_rst = rst; a_en = en; a_dir = dir; a_sat = sat; a_load = load; a_lv = 4'(lv);
    endtask

    task automatic set_b(input bit rst, input bit en, input bit dir, input bit sat,
                         input bit load, input int lv);
        b_rst = rst; b_en = en; b_dir = dir; b_sat = sat; b_load = load; b_lv = 2'(lv);
    endtask

    // Advance one clock and step both models with the inputs seen at the edge
    task automatic tick_clk();
        @(posedge clk);
        #1;
        ma = model_next(ma, 9, 4, a_rst, a_en, a_dir, a_sat, a_load, int'(a_lv));
        mb = model_next(mb, 3, 1, b_rst, b_en, b_dir, b_sat, b_load, int'(b_lv));
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_a(input string tag);
        check({tag, ".count"}, 32'(a_count), ma.count);
        check({tag, ".tick"},  32'(a_tick),  32'(ma.tick));
        check({tag, ".tc"},    32'(a_tc),    32'(ma.tc));
        check({tag, ".at_max"},  32'(a_amax),  32'(ma.count == 9));
        check({tag, ".at_zero"}, 32'(a_azero), 32'(ma.count == 0));
    endtask

    task automatic check_b(input string tag);
        check({tag, ".count"}, 32'(b_count), mb.count);
        check({tag, ".tick"},  32'(b_tick),  32'(mb.tick));
        check({tag, ".tc"},    32'(b_tc),    32'(mb.tc));
        check({tag, ".at_max"},  32'(b_amax),  32'(mb.count == 3));
        check({tag, ".at_zero"}, 32'(b_azero), 32'(mb.count == 0));
    endtask

    typedef struct {
        bit rst, en, dir, sat, load;
        int lv;
        int count;
        bit tick, tc, amax, azero;
    } vec_t;

    vec_t tbl[22];

    initial begin
        int ticks, tcs;
        int exp_seq[6];
        bit exp_tc[6];
        int down_seq[5];

        // rst en dir sat load lv | count tick tc at_max at_zero
        tbl[0]  = '{1,0,0,0,0, 0,  0,0,0,0,1};  // reset
        tbl[1]  = '{0,0,0,0,1,15,  9,0,0,1,0};  // load clamps 15 -> 9
        tbl[2]  = '{0,1,1,0,0, 0,  9,0,0,1,0};
        tbl[3]  = '{0,1,1,0,0, 0,  9,0,0,1,0};
        tbl[4]  = '{0,1,1,0,0, 0,  9,0,0,1,0};
        tbl[5]  = '{0,1,1,0,0, 0,  0,1,1,0,1};  // wrap 9 -> 0
        tbl[6]  = '{0,1,1,0,0, 0,  0,0,0,0,1};
        tbl[7]  = '{0,0,1,0,1, 3,  3,0,0,0,0};  // load while disabled
        tbl[8]  = '{0,1,0,1,0, 0,  3,0,0,0,0};
        tbl[9]  = '{0,1,0,1,0, 0,  3,0,0,0,0};
        tbl[10] = '{0,1,0,1,0, 0,  3,0,0,0,0};
        tbl[11] = '{0,1,0,1,0, 0,  2,1,0,0,0};  // down step
        tbl[12] = '{0,1,0,1,0, 0,  2,0,0,0,0};
        tbl[13] = '{0,1,0,1,0, 0,  2,0,0,0,0};
        tbl[14] = '{0,1,0,1,0, 0,  2,0,0,0,0};
        tbl[15] = '{0,1,0,1,1, 7,  7,0,0,0,0};  // load on tick cycle wins
        tbl[16] = '{0,1,0,1,0, 0,  7,0,0,0,0};
        tbl[17] = '{1,1,1,0,0, 0,  0,0,0,0,1};  // reset mid-prescale
        tbl[18] = '{0,1,1,0,0, 0,  0,0,0,0,1};
        tbl[19] = '{0,1,1,0,0, 0,  0,0,0,0,1};
        tbl[20] = '{0,1,1,0,0, 0,  0,0,0,0,1};
        tbl[21] = '{0,1,1,0,0, 0,  1,1,0,0,0};  // full period after reset

        set_a(1, 0, 0, 0, 0, 0);
        set_b(1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 22; i++) begin
            set_a(tbl[i].rst, tbl[i].en, tbl[i].dir, tbl[i].sat, tbl[i].load, tbl[i].lv);
            tick_clk();
            check($sformatf("tbl%0d.count", i),   32'(a_count), tbl[i].count);
            check($sformatf("tbl%0d.tick", i),    32'(a_tick),  32'(tbl[i].tick));
            check($sformatf("tbl%0d.tc", i),      32'(a_tc),    32'(tbl[i].tc));
            check($sformatf("tbl%0d.at_max", i),  32'(a_amax),  32'(tbl[i].amax));
            check($sformatf("tbl%0d.at_zero", i), 32'(a_azero), 32'(tbl[i].azero));
        end

        // Up-count with wrap over 40 cycles
        set_a(1, 0, 0, 0, 0, 0);
        tick_clk();
        check_a("t1.reset");
        set_a(0, 1, 1, 0, 0, 0);
        ticks = 0; tcs = 0;
        for (int i = 0; i < 40; i++) begin
            tick_clk();
            check_a("t1");
            if (a_tick) begin
                ticks++;
                check("t1.step_value", 32'(a_count), ticks % 10);
                check("t1.tick_phase", (i + 1) % 4, 0);
            end
            if (a_tc) tcs++;
        end
        check("t1.ticks", ticks, 10);
        check("t1.tc_pulses", tcs, 1);

        // Saturating down-count from 3
        set_a(0, 0, 0, 1, 1, 3);
        tick_clk();
        check_a("t2.load");
        set_a(0, 1, 0, 1, 0, 0);
        down_seq = '{2, 1, 0, 0, 0};
        ticks = 0; tcs = 0;
        for (int i = 0; i < 20; i++) begin
            tick_clk();
            check_a("t2");
            if (a_tick) begin
                if (ticks < 5) check("t2.step_value", 32'(a_count), down_seq[ticks]);
                ticks++;
            end
            if (a_tc) tcs++;
        end
        check("t2.ticks", ticks, 5);
        check("t2.tc_pulses", tcs, 2);
        check("t2.at_zero", 32'(a_azero), 1);

        // Load above MAX_VALUE then wrap upward
        set_a(0, 0, 1, 0, 1, 15);
        tick_clk();
        check("t3.count", 32'(a_count), 9);
        check("t3.at_max", 32'(a_amax), 1);
        set_a(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick_clk();
            check_a("t3");
        end
        check("t3.wrap_count", 32'(a_count), 0);
        check("t3.wrap_tc", 32'(a_tc), 1);

        // Hold at ps=2, then resume: step exactly 2 enabled cycles later
        set_a(0, 1, 1, 0, 0, 0);
        tick_clk();
        tick_clk();
        check_a("t4.pre");
        set_a(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick_clk();
            check("t4.hold_tick", 32'(a_tick), 0);
            check("t4.hold_count", 32'(a_count), 0);
        end
        set_a(0, 1, 1, 0, 0, 0);
        tick_clk();
        check("t4.resume1_tick", 32'(a_tick), 0);
        tick_clk();
        check("t4.resume2_tick", 32'(a_tick), 1);
        check("t4.resume2_count", 32'(a_count), 1);

        // PRESCALE=1 down-count with wrap
        set_b(1, 0, 0, 0, 0, 0);
        tick_clk();
        check_b("t6.reset");
        set_b(0, 1, 0, 0, 0, 0);
        exp_seq = '{3, 2, 1, 0, 3, 2};
        exp_tc  = '{1, 0, 0, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            tick_clk();
            check($sformatf("t6.count%0d", i), 32'(b_count), exp_seq[i]);
            check($sformatf("t6.tick%0d", i),  32'(b_tick), 1);
            check($sformatf("t6.tc%0d", i),    32'(b_tc), 32'(exp_tc[i]));
        end

        // Randomized traffic on both instances against the model
        for (int i = 0; i < 400; i++) begin
            set_a(($urandom_range(49) == 0), ($urandom_range(3) != 0), 1'($urandom),
                  1'($urandom), ($urandom_range(11) == 0), $urandom_range(15));
            set_b(($urandom_range(49) == 0), ($urandom_range(3) != 0), 1'($urandom),
                  1'($urandom), ($urandom_range(11) == 0), $urandom_range(3));
            tick_clk();
            check_a("rnd_a");
            check_b("rnd_b");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
